// File: rtl/f1_sequencer.sv
// F1 start-lights sequencer: paces the lights shifter, holds for a random delay, then times the driver.
// Define F1_SEQ_BEST_TIME_EN to add the best_rt output, which tracks the fastest completed reaction.
module f1_sequencer #(
    parameter int TICK_CYCLES     = 50,
    parameter int DELAY_MIN_TICKS = 1,
    parameter int RT_W            = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            react,
    output logic            step_en,
    output logic            lights_clr,
    output logic            busy,
    output logic            rt_valid,
    output logic [RT_W-1:0] rt_count,
    output logic            jump_start
`ifdef F1_SEQ_BEST_TIME_EN
    ,
    output logic [RT_W-1:0] best_rt
`endif
);

    localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int DLY_W  = $clog2(128 + DELAY_MIN_TICKS) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    // IDLE wait trigger | LIGHTING 8 steps | HOLD random delay | TIMING count | DONE result | FAULT jump start
    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTING,
        S_HOLD,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TICK_W-1:0] r_tick;
    logic [3:0]        r_step;
    logic [DLY_W-1:0]  r_delay;
    logic [6:0]        r_lfsr;
    logic              r_react_q;
    logic [RT_W-1:0]   r_rt;
    logic              r_fault_entry;

    logic              w_tick;
    logic              w_react_rise;
    logic [RT_W-1:0]   w_rt_inc;

    assign w_tick       = (r_tick == TICK_LAST);
    assign w_react_rise = react & ~r_react_q;
    assign w_rt_inc     = (r_rt == {RT_W{1'b1}}) ? r_rt : r_rt + RT_W'(1);

    always_comb begin
        w_next     = r_state;
        step_en    = 1'b0;
        lights_clr = r_fault_entry;
        case (r_state)
            S_IDLE: begin
                if (trigger) w_next = S_LIGHTING;
            end
            S_LIGHTING: begin
                if (w_react_rise) begin
                    w_next = S_FAULT;
                end else if (w_tick) begin
                    step_en = 1'b1;
                    if (r_step == 4'd7) w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_react_rise) begin
                    w_next = S_FAULT;
                end else if (w_tick && (r_delay == DLY_W'(1))) begin
                    lights_clr = 1'b1;
                    w_next     = S_TIMING;
                end
            end
            S_TIMING: begin
                if (w_react_rise) w_next = S_DONE;
            end
            S_DONE, S_FAULT: begin
                if (trigger) w_next = S_LIGHTING;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_step        <= '0;
            r_delay       <= '0;
            r_lfsr        <= 7'h01;
            r_react_q     <= 1'b0;
            r_rt          <= '0;
            r_fault_entry <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_lfsr        <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_react_q     <= react;
            // FAULT clears the lights once, on its first cycle only
            r_fault_entry <= (w_next == S_FAULT) && (r_state != S_FAULT);

            if ((w_next != r_state) || w_tick) r_tick <= '0;
            else                               r_tick <= r_tick + TICK_W'(1);

            if ((r_state != S_LIGHTING) && (w_next == S_LIGHTING)) r_step <= '0;
            else if (step_en)                                      r_step <= r_step + 4'd1;

            if ((r_state != S_HOLD) && (w_next == S_HOLD))
                r_delay <= DLY_W'(r_lfsr) + DLY_W'(DELAY_MIN_TICKS);
            else if ((r_state == S_HOLD) && w_tick)
                r_delay <= r_delay - DLY_W'(1);

            if ((r_state != S_TIMING) && (w_next == S_TIMING)) r_rt <= '0;
            else if (r_state == S_TIMING)                      r_rt <= w_rt_inc;
            else if ((r_state == S_DONE) && (w_next != S_DONE)) r_rt <= '0;
        end
    end

    assign busy       = (r_state == S_LIGHTING) || (r_state == S_HOLD) || (r_state == S_TIMING);
    assign rt_valid   = (r_state == S_DONE);
    assign jump_start = (r_state == S_FAULT);
    assign rt_count   = r_rt;

`ifdef F1_SEQ_BEST_TIME_EN
    logic [RT_W-1:0] r_best;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= {RT_W{1'b1}};
        end else if ((r_state == S_TIMING) && (w_next == S_DONE) && (w_rt_inc < r_best)) begin
            r_best <= w_rt_inc;
        end
    end

    assign best_rt = r_best;
`endif

endmodule

// File: tb/tb_f1_sequencer.sv
// Bench for f1_sequencer: scoreboarded step/clear/reaction events at TICK_CYCLES=4, plus a 4-bit RT instance.
// Best-time checks are compiled in when F1_SEQ_BEST_TIME_EN is defined.
module tb_f1_sequencer;

    localparam int TICK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, trigger, react, trigger2, react2;
    logic        step_en, lights_clr, busy, rt_valid, jump_start;
    logic [15:0] rt_count;
    logic        step_en2, lights_clr2, busy2, rt_valid2, jump_start2;
    logic [3:0]  rt_count2;
`ifdef F1_SEQ_BEST_TIME_EN
    logic [15:0] best_rt;
    logic [3:0]  best_rt2;
`endif

    f1_sequencer #(.TICK_CYCLES(TICK), .DELAY_MIN_TICKS(1), .RT_W(16)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .react(react),
        .step_en(step_en), .lights_clr(lights_clr), .busy(busy), .rt_valid(rt_valid),
        .rt_count(rt_count), .jump_start(jump_start)
`ifdef F1_SEQ_BEST_TIME_EN
        , .best_rt(best_rt)
`endif
    );

    f1_sequencer #(.TICK_CYCLES(TICK), .DELAY_MIN_TICKS(1), .RT_W(4)) dut_s (
        .clk(clk), .rst(rst), .trigger(trigger2), .react(react2),
        .step_en(step_en2), .lights_clr(lights_clr2), .busy(busy2), .rt_valid(rt_valid2),
        .rt_count(rt_count2), .jump_start(jump_start2)
`ifdef F1_SEQ_BEST_TIME_EN
        , .best_rt(best_rt2)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_step2 = 0;
    logic [6:0] m_lfsr = 7'h01;
    int         exp_step[$];
    int         exp_clr[$];
    int         exp_rt[$];
    int         exp_rt2[$];
    logic       rt_valid_q = 1'b0;
    logic       rt_valid2_q = 1'b0;

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [6:0] lfsr_adv(input logic [6:0] v, input int n);
        logic [6:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6] ^ r[5]};
        return r;
    endfunction

    // Cycle count and reference LFSR advance on the same edge as the DUT
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= 7'h01;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            if (exp_step.size() == 0) check_val("step_unexpected", cyc, -1);
            else                      check_val("step_cycle", cyc, exp_step.pop_front());
        end
        if (lights_clr === 1'b1) begin
            if (exp_clr.size() == 0) check_val("clr_unexpected", cyc, -1);
            else                     check_val("clr_cycle", cyc, exp_clr.pop_front());
        end
        if (rt_valid === 1'b1 && rt_valid_q !== 1'b1) begin
            if (exp_rt.size() == 0) check_val("rt_unexpected", rt_count, -1);
            else                    check_val("rt_count", rt_count, exp_rt.pop_front());
        end
        rt_valid_q = rt_valid;
        if (rt_valid2 === 1'b1 && rt_valid2_q !== 1'b1) begin
            if (exp_rt2.size() == 0) check_val("rt2_unexpected", rt_count2, -1);
            else                     check_val("rt2_count", rt_count2, exp_rt2.pop_front());
        end
        rt_valid2_q = rt_valid2;
        if (step_en2 === 1'b1) n_step2++;
    end

    task automatic wait_clr(output int l_cyc);
        l_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lights_clr === 1'b1) begin
                l_cyc = cyc;
                break;
            end
        end
        if (l_cyc < 0) begin
            check_val("clr_timeout", 0, 1);
            l_cyc = cyc;
        end
    endtask

    // Trigger a run; queue the 8 step pulses and, optionally, the hold-expiry clear
    task automatic start_run(input int hold_trig, input bit push_clr, output int l_exp);
        int         c0;
        logic [6:0] lv;
        c0 = cyc;
        lv = lfsr_adv(m_lfsr, 8 * TICK);
        for (int k = 1; k <= 8; k++) exp_step.push_back(c0 + TICK * k);
        l_exp = c0 + 8 * TICK + TICK * (int'(lv) + 1);
        if (push_clr) exp_clr.push_back(l_exp);
        trigger = 1'b1;
        @(negedge clk);
        check_val("start_busy", busy, 1);
        check_val("start_jump", jump_start, 0);
        check_val("start_rt_cleared", rt_count, 0);
        check_val("start_rt_valid", rt_valid, 0);
        for (int i = 1; i < hold_trig; i++) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic finish_run(input int rt, input int l_cyc);
        while (cyc < l_cyc + rt) @(negedge clk);
        react = 1'b1;
        exp_rt.push_back(rt);
        @(negedge clk);
        react = 1'b0;
        @(negedge clk);
        check_val("done_valid", rt_valid, 1);
        check_val("done_busy", busy, 0);
    endtask

    task automatic do_jump(input bit react_with_trig);
        int c0;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) exp_step.push_back(c0 + TICK * k);
        trigger = 1'b1;
        if (react_with_trig) react = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        react   = 1'b0;
        check_val("jump_run_busy", busy, 1);
        check_val("jump_run_nofault", jump_start, 0);
        while (cyc < c0 + 3 * TICK + 2) @(negedge clk);
        react = 1'b1;
        exp_clr.push_back(c0 + 3 * TICK + 3);
        @(negedge clk);
        check_val("jump_flag", jump_start, 1);
        check_val("jump_not_busy", busy, 0);
        react = 1'b0;
        while (cyc < c0 + 6 * TICK) @(negedge clk);
        check_val("jump_held", jump_start, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int l_exp;
        int l_cyc;
        int n_idle_steps;
        int n_idle_clr;

        rst = 1'b1; trigger = 1'b0; react = 1'b0; trigger2 = 1'b0; react2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_step_en", step_en, 0);
        check_val("rst_lights_clr", lights_clr, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_rt_valid", rt_valid, 0);
        check_val("rst_rt_count", rt_count, 0);
        check_val("rst_jump", jump_start, 0);
        @(negedge clk);

        // Normal run with trigger held into LIGHTING (ignored), reaction at 10
        start_run(6, 1'b1, l_exp);
        wait_clr(l_cyc);
        finish_run(10, l_cyc);
        check_val("done_rt_held", rt_count, 10);

        // Trigger and react edge together in DONE, then jump start before step 4
        do_jump(1'b1);

        // Restart from FAULT; react edge lands on the hold-expiry cycle
        start_run(1, 1'b0, l_exp);
        while (cyc < l_exp) @(negedge clk);
        react = 1'b1;
        exp_clr.push_back(l_exp + 1);
        @(negedge clk);
        check_val("expiry_edge_fault", jump_start, 1);
        check_val("expiry_edge_busy", busy, 0);
        react = 1'b0;
        @(negedge clk);

        // Button pressed in FAULT and held through a whole start: no fault, then release and press
        react = 1'b1;
        @(negedge clk);
        check_val("fault_press_ignored", jump_start, 1);
        start_run(1, 1'b1, l_exp);
        wait_clr(l_cyc);
        check_val("held_no_fault", jump_start, 0);
        react = 1'b0;
        finish_run(5, l_cyc);

        // Reset two cycles mid-TIMING
        start_run(1, 1'b1, l_exp);
        wait_clr(l_cyc);
        repeat (3) @(negedge clk);
        check_val("timing_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_rt_count", rt_count, 0);
        check_val("midrst_rt_valid", rt_valid, 0);
        check_val("midrst_jump", jump_start, 0);
        n_idle_steps = 0;
        n_idle_clr   = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_en === 1'b1) n_idle_steps++;
            if (lights_clr === 1'b1) n_idle_clr++;
        end
        check_val("idle_steps", n_idle_steps, 0);
        check_val("idle_clr", n_idle_clr, 0);

`ifdef F1_SEQ_BEST_TIME_EN
        check_val("best_reset", best_rt, 16'hFFFF);
        start_run(1, 1'b1, l_exp); wait_clr(l_cyc); finish_run(12, l_cyc);
        check_val("best_after_12", best_rt, 12);
        start_run(1, 1'b1, l_exp); wait_clr(l_cyc); finish_run(7, l_cyc);
        check_val("best_after_7", best_rt, 7);
        start_run(1, 1'b1, l_exp); wait_clr(l_cyc); finish_run(9, l_cyc);
        check_val("best_after_9", best_rt, 7);
        do_jump(1'b0);
        check_val("best_after_fault", best_rt, 7);
`endif

        // Saturation on the 4-bit reaction counter
        n_step2 = 0;
        trigger2 = 1'b1;
        @(negedge clk);
        trigger2 = 1'b0;
        check_val("sat_busy", busy2, 1);
        l_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lights_clr2 === 1'b1) begin
                l_cyc = cyc;
                break;
            end
        end
        if (l_cyc < 0) begin
            check_val("sat_clr_timeout", 0, 1);
            l_cyc = cyc;
        end
        check_val("sat_steps", n_step2, 8);
        while (cyc < l_cyc + 10) @(negedge clk);
        check_val("sat_rt_mid", rt_count2, 9);
        while (cyc < l_cyc + 30) @(negedge clk);
        check_val("sat_rt_held", rt_count2, 15);
        check_val("sat_not_valid", rt_valid2, 0);
        check_val("sat_no_jump", jump_start2, 0);
        react2 = 1'b1;
        exp_rt2.push_back(15);
        @(negedge clk);
        react2 = 1'b0;
        @(negedge clk);
        check_val("sat_valid", rt_valid2, 1);
        check_val("sat_rt_final", rt_count2, 15);

        repeat (4) @(negedge clk);
        check_val("left_steps", exp_step.size(), 0);
        check_val("left_clr", exp_clr.size(), 0);
        check_val("left_rt", exp_rt.size(), 0);
        check_val("left_rt2", exp_rt2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
